// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store, data first with a starvation bound on fetch.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DM_BURST = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                dm_read,
  input  logic                dm_write,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wmask,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  input  logic                halt,
  output logic                busy
);
  localparam int SW = $clog2(MAX_DM_BURST + 1);
  localparam logic [SW-1:0] MAXC = SW'(MAX_DM_BURST);
  typedef enum logic [1:0] {IDLE, ISSUE_IF, ISSUE_DM, RESP} state_t;
  state_t r_state, w_next;
  logic [SW-1:0] r_cnt;
  logic r_owner_dm, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_dm_rdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic w_idle, w_if_ok, w_grant_dm, w_grant_if;
  assign w_idle     = r_state == IDLE;
  assign w_if_ok    = if_req & ~halt;
  assign w_grant_dm = w_idle & (dm_read | dm_write) & (~w_if_ok | (r_cnt < MAXC));
  assign w_grant_if = w_idle & ~w_grant_dm & w_if_ok;
  always_comb begin
    w_next = w_idle ? (w_grant_dm ? ISSUE_DM : w_grant_if ? ISSUE_IF : IDLE)
           : r_state == RESP ? IDLE
           : mem_ack ? RESP : r_state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_owner_dm <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (w_grant_dm) begin
        r_addr     <= dm_addr;
        r_wdata    <= dm_wdata;
        r_wmask    <= dm_write ? dm_wmask : '1;
        r_we       <= dm_write;
        r_owner_dm <= 1'b1;
        r_cnt      <= !w_if_ok ? '0 : r_cnt == MAXC ? MAXC : r_cnt + SW'(1);
      end else if (w_grant_if) begin
        r_addr     <= if_addr;
        r_wmask    <= '1;
        r_we       <= 1'b0;
        r_owner_dm <= 1'b0;
        r_cnt      <= '0;
      end
      if (r_state == ISSUE_IF && mem_ack) r_if_rdata <= mem_rdata;
      if (r_state == ISSUE_DM && mem_ack) r_dm_rdata <= mem_rdata;
    end
  end
  assign mem_req   = r_state == ISSUE_IF || r_state == ISSUE_DM;
  assign busy      = ~w_idle;
  assign if_ack    = r_state == RESP && !r_owner_dm;
  assign dm_ack    = r_state == RESP && r_owner_dm;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench with a behavioural wait-state memory.
module tb_mem_port_arbiter;
  typedef struct {
    logic        dm;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
  } txn_t;
  logic clk = 0, reset_n = 0, if_req = 0, dm_read = 0, dm_write = 0, halt = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [3:0] dm_wmask = 0;
  logic if_ack, dm_ack, mem_req, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_wmask;
  mem_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wmask(dm_wmask), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halt(halt), .busy(busy)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  txn_t exp_q[$], rec_q[$];
  txn_t snap, e, r;
  int mem_wait = 0, wcnt = 0, req_cycles = 0, last_req_cycles = 0;
  bit in_txn = 0, stray = 0, ovr_en = 0;
  logic [31:0] ovr_data = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(logic dm, logic [31:0] a, logic we, logic [31:0] wd, logic [3:0] wm, logic [31:0] rd);
    txn_t t;
    t.dm = dm; t.addr = a; t.we = we; t.wdata = wd; t.wmask = wm; t.rdata = rd;
    exp_q.push_back(t);
  endtask

  task automatic serve(int n);
    int seen = 0;
    for (int c = 0; c < 400 && seen < n; c++) begin
      @(negedge clk);
      if (if_ack || dm_ack) seen++;
    end
    if (seen < n) begin
      tests++; fails++;
      $display("FAIL serve_timeout: saw %0d acks, required %0d", seen, n);
    end
  endtask

  task automatic wait_req();
    int c = 0;
    while (!mem_req && c < 50) begin @(negedge clk); c++; end
    if (!mem_req) begin
      tests++; fails++;
      $display("FAIL mem_req_timeout: mem_req %b required 1", mem_req);
    end
  endtask

  // memory model: acks after mem_wait extra cycles, data = addr ^ 0x0F0F0000 unless overridden
  always @(negedge clk) begin
    if (mem_ack) mem_ack = 0;
    else if (!mem_req) begin
      in_txn = 0;
      if (stray) begin mem_ack = 1; mem_rdata = 32'hBAD0BAD0; stray = 0; end
    end else begin
      if (!in_txn) begin
        in_txn = 1; wcnt = 0; req_cycles = 0;
        snap.addr = mem_addr; snap.we = mem_we; snap.wdata = mem_wdata; snap.wmask = mem_wmask;
      end else
        chk("stable_fields", {31'd0, mem_addr == snap.addr && mem_we == snap.we &&
            mem_wdata == snap.wdata && mem_wmask == snap.wmask}, 1);
      req_cycles++;
      if (wcnt == mem_wait) begin
        mem_ack = 1;
        mem_rdata = ovr_en ? ovr_data : mem_addr ^ 32'h0F0F0000;
        rec_q.push_back(snap);
        last_req_cycles = req_cycles;
        in_txn = 0;
      end else wcnt++;
    end
  end

  always @(negedge clk) begin
    if (reset_n && (if_ack || dm_ack)) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_ack: if_ack=%b dm_ack=%b, no transaction expected", if_ack, dm_ack);
      end else begin
        e = exp_q.pop_front();
        chk("ack_port_dm", {31'd0, dm_ack}, {31'd0, e.dm});
        chk("ack_both", {31'd0, if_ack & dm_ack}, 0);
        chk("rdata", e.dm ? dm_rdata : if_rdata, e.rdata);
        if (rec_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL mem_txn_missing: ack with no memory transaction recorded, required one");
        end else begin
          r = rec_q.pop_front();
          chk("mem_addr", r.addr, e.addr);
          chk("mem_we", {31'd0, r.we}, {31'd0, e.we});
          chk("mem_wmask", {28'd0, r.wmask}, {28'd0, e.wmask});
          if (e.we) chk("mem_wdata", r.wdata, e.wdata);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_if_ack", {31'd0, if_ack}, 0);
    chk("rst_dm_ack", {31'd0, dm_ack}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    reset_n = 1;
    @(negedge clk);
    // single zero-wait fetch
    ovr_en = 1; ovr_data = 32'h00500093; mem_wait = 0;
    push(0, 32'h100, 0, 0, 4'hF, 32'h00500093);
    if_req = 1; if_addr = 32'h100;
    serve(1);
    if_req = 0; ovr_en = 0;
    chk("fetch_req_cycles", last_req_cycles, 1);
    // store with 3 wait states
    @(negedge clk);
    mem_wait = 3;
    push(1, 32'h2000, 1, 32'hDEADBEEF, 4'hF, 32'h0F0F2000);
    dm_write = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_wmask = 4'hF;
    serve(1);
    dm_write = 0;
    chk("store_req_cycles", last_req_cycles, 4);
    // contention: DM x4 then IF, twice
    @(negedge clk);
    mem_wait = 0;
    for (int i = 0; i < 10; i++)
      if (i % 5 == 4) push(0, 32'h100, 0, 0, 4'hF, 32'h0F0F0100);
      else push(1, 32'h3000, 0, 0, 4'hF, 32'h0F0F3000);
    if_req = 1; if_addr = 32'h100; dm_read = 1; dm_addr = 32'h3000; dm_wmask = 4'h1;
    serve(10);
    if_req = 0; dm_read = 0;
    // halt: only data served, fetch follows right after halt falls
    @(negedge clk);
    for (int i = 0; i < 3; i++) push(1, 32'h3000, 0, 0, 4'hF, 32'h0F0F3000);
    push(0, 32'h100, 0, 0, 4'hF, 32'h0F0F0100);
    halt = 1; if_req = 1; dm_read = 1;
    serve(3);
    dm_read = 0; halt = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!if_ack && lat < 20);
    chk("halt_release_latency", lat, 3);
    if_req = 0;
    // fetch in flight when halt rises still completes
    @(negedge clk);
    mem_wait = 3;
    push(0, 32'h180, 0, 0, 4'hF, 32'h0F0F0180);
    if_req = 1; if_addr = 32'h180;
    wait_req();
    halt = 1;
    serve(1);
    if_req = 0; halt = 0;
    // reset during a data access
    @(negedge clk);
    mem_wait = 5;
    dm_read = 1; dm_addr = 32'h4000;
    wait_req();
    #2 reset_n = 0;
    #1;
    chk("rst_mid_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    chk("rst_mid_mem_wmask", {28'd0, mem_wmask}, 0);
    chk("rst_mid_dm_rdata", dm_rdata, 0);
    chk("rst_mid_if_rdata", if_rdata, 0);
    chk("rst_mid_dm_ack", {31'd0, dm_ack}, 0);
    dm_read = 0;
    @(negedge clk);
    reset_n = 1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 0);
    // stray mem_ack in IDLE is ignored
    stray = 1;
    repeat (3) @(negedge clk);
    chk("stray_busy", {31'd0, busy}, 0);
    chk("stray_mem_req", {31'd0, mem_req}, 0);
    // read and write together behave as a write
    mem_wait = 1;
    push(1, 32'h5000, 1, 32'h12345678, 4'h3, 32'h0F0F5000);
    dm_read = 1; dm_write = 1; dm_addr = 32'h5000; dm_wdata = 32'h12345678; dm_wmask = 4'h3;
    serve(1);
    dm_read = 0; dm_write = 0;
    repeat (5) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
